// File: rtl/preadd_mult_stage_if.sv
// Handshake/data bundle for the pre-adder/multiplier stage.
// master drives operands, opmode, valid and CEs; slave returns bcout/m_out/m_valid.
interface preadd_mult_stage_if #(
  parameter int WIDTH = 18
);
  logic               ce_a1;
  logic               ce_b1;
  logic               ce_m;
  logic               in_valid;
  logic               preadd_en;
  logic               preadd_sub;
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic [WIDTH-1:0]   d_in;
  logic [WIDTH-1:0]   bcout;
  logic [2*WIDTH-1:0] m_out;
  logic               m_valid;

  modport master (
    output ce_a1, ce_b1, ce_m,
    output in_valid, preadd_en, preadd_sub,
    output a_in, b_in, d_in,
    input  bcout, m_out, m_valid
  );

  modport slave (
    input  ce_a1, ce_b1, ce_m,
    input  in_valid, preadd_en, preadd_sub,
    input  a_in, b_in, d_in,
    output bcout, m_out, m_valid
  );
endinterface

// File: rtl/preadd_mult_stage.sv
// DSP pre-adder (D+B / D-B / B), optional B1/A1 register, signed multiply, optional M register.
// Ports: clk, rst (sync, active-low), bus (slave: operands/CEs in, bcout/m_out/m_valid out).
module preadd_mult_stage #(
  parameter int WIDTH = 18,
  parameter bit B1REG = 1'b1,
  parameter bit MREG  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  preadd_mult_stage_if.slave   bus
);

  logic [WIDTH-1:0]          pre;
  logic [WIDTH-1:0]          a1;
  logic [WIDTH-1:0]          b1;
  logic                      v1;
  logic signed [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0]        m;
  logic                      v2;

  // Truncating add/sub: carry and borrow fall off the top.
  always_comb begin
    pre = bus.b_in;
    case ({bus.preadd_en, bus.preadd_sub})
      2'b10:   pre = bus.d_in + bus.b_in;
      2'b11:   pre = bus.d_in - bus.b_in;
      default: pre = bus.b_in;
    endcase
  end

  if (B1REG) begin : g_b1
    logic [WIDTH-1:0] a1_q, a1_d;
    logic [WIDTH-1:0] b1_q, b1_d;
    logic             v1_q, v1_d;

    // A split CE loads only half of the pair, so the slot is marked invalid.
    always_comb begin
      a1_d = a1_q;
      b1_d = b1_q;
      v1_d = v1_q;
      if (bus.ce_a1) a1_d = bus.a_in;
      if (bus.ce_b1) b1_d = pre;
      if (bus.ce_a1 | bus.ce_b1)
        v1_d = bus.in_valid & bus.ce_a1 & bus.ce_b1;
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        a1_q <= '0;
        b1_q <= '0;
        v1_q <= 1'b0;
      end else begin
        a1_q <= a1_d;
        b1_q <= b1_d;
        v1_q <= v1_d;
      end
    end

    assign a1 = a1_q;
    assign b1 = b1_q;
    assign v1 = v1_q;
  end else begin : g_b1_byp
    assign a1 = bus.a_in;
    assign b1 = pre;
    assign v1 = bus.in_valid;
  end

  // Both operands sign-extend to 2*WIDTH, so the product is exact.
  assign prod = $signed(a1) * $signed(b1);

  if (MREG) begin : g_m
    logic [2*WIDTH-1:0] m_q, m_d;
    logic               v2_q, v2_d;

    always_comb begin
      m_d  = m_q;
      v2_d = v2_q;
      if (bus.ce_m) begin
        m_d  = prod;
        v2_d = v1;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        m_q  <= '0;
        v2_q <= 1'b0;
      end else begin
        m_q  <= m_d;
        v2_q <= v2_d;
      end
    end

    assign m  = m_q;
    assign v2 = v2_q;
  end else begin : g_m_byp
    assign m  = prod;
    assign v2 = v1;
  end

  assign bus.bcout   = b1;
  assign bus.m_out   = m;
  assign bus.m_valid = v2;

endmodule
